// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared constants and helpers for the multiport register file.
//   RF_ADDR_ZERO     : address of the hardwired-zero register
//   RF_WRITE_ENABLED : active level of a write-port enable
//   RF_DBG_FMT       : format string for printing one debug write record
//                      (address, old value, new value)
//   rfPendMax()      : saturation value of a pending counter of given width
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int    RF_ADDR_ZERO     = 0;
    localparam logic  RF_WRITE_ENABLED = 1'b1;
    localparam string RF_DBG_FMT       = "rf write r%0d old=%h new=%h";

    // Largest count a pending counter of pendW bits can hold; a reservation
    // arriving at this value is dropped and reported as an overflow.
    function automatic int rfPendMax(input int pendW);
        return (1 << pendW) - 1;
    endfunction

endpackage

// File: rtl/rf_pend_ctr.sv
// ---------------------------------------------------------------------------
// rf_pend_ctr
// Saturating up/down pending-write counter for a single register.
//   clk    : clock, state updates on posedge
//   reset  : synchronous active-high, clears the count
//   inc_i  : a producer reserved this register this cycle
//   dec_i  : a write to this register retires this cycle (already clamped to 1)
//   cnt_o  : current number of outstanding writes
//   ovf_o  : combinational, the reservation this cycle is being dropped
//            because the counter is already at its maximum
// ---------------------------------------------------------------------------
module rf_pend_ctr
    import rf_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              ovf_o
);

    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(rfPendMax(PEND_W));

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;

    // Next count: a simultaneous reserve and retire cancel out, a lone
    // reserve saturates at the maximum and a lone retire floors at zero so a
    // write to an unreserved register is harmless.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = inc_i && !dec_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/rf_multiport.sv
// ---------------------------------------------------------------------------
// rf_multiport
// Parametrised register file with NUM_RD combinational read ports, NUM_WR
// write ports, same-cycle write-to-read bypass and a per-register pending
// write scoreboard. Register 0 always reads zero and is never pending.
//   clk, reset   : clock and synchronous active-high reset
//   rd_addr      : NUM_RD packed read addresses
//   rd_data      : NUM_RD packed read data (bypassed from this cycle's writes)
//   rd_pend      : per read port, register still has outstanding writes
//   wr_en/addr/data : NUM_WR packed write ports, highest index wins
//   rsv_en/addr  : reservation of a register by an issuing producer
//   rsv_ovf      : registered pulse, a reservation was dropped (saturated)
//   dbg_wr_*     : registered record of the highest-index committed write
// ---------------------------------------------------------------------------
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int PEND_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ovf,
    output logic                     dbg_wr_vld,
    output logic [ADDR_W-1:0]        dbg_wr_addr,
    output logic [DATA_W-1:0]        dbg_wr_old,
    output logic [DATA_W-1:0]        dbg_wr_new
);

    localparam int                NUM_REGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(RF_ADDR_ZERO);

    logic [DATA_W-1:0]                  mem_q [NUM_REGS];
    logic [NUM_REGS-1:0]                wrHit;
    logic [NUM_REGS-1:0][DATA_W-1:0]    wrVal;
    logic [NUM_REGS-1:0][PEND_W-1:0]    cnt;
    logic [NUM_REGS-1:0]                ovfVec;

    logic              rsvOvf_q;
    logic              dbgVld_q,  dbgVld_d;
    logic [ADDR_W-1:0] dbgAddr_q, dbgAddr_d;
    logic [DATA_W-1:0] dbgOld_q,  dbgOld_d;
    logic [DATA_W-1:0] dbgNew_q,  dbgNew_d;

    assign wrHit[0]  = 1'b0;
    assign wrVal[0]  = '0;
    assign cnt[0]    = '0;
    assign ovfVec[0] = 1'b0;

    for (genvar a = 1; a < NUM_REGS; a++) begin : gReg
        logic              hit;
        logic [DATA_W-1:0] val;

        // Priority encode of the write ports for this register: scanning
        // upward lets the highest-index port overwrite lower ones, and the
        // same result drives both the commit and the read bypass.
        always_comb begin
            hit = 1'b0;
            val = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] == RF_WRITE_ENABLED &&
                    wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(a)) begin
                    hit = 1'b1;
                    val = wr_data[j*DATA_W +: DATA_W];
                end
            end
        end

        assign wrHit[a] = hit;
        assign wrVal[a] = val;

        rf_pend_ctr #(
            .PEND_W (PEND_W)
        ) uPendCtr (
            .clk    (clk),
            .reset  (reset),
            .inc_i  (rsv_en && (rsv_addr == ADDR_W'(a))),
            .dec_i  (hit),
            .cnt_o  (cnt[a]),
            .ovf_o  (ovfVec[a])
        );
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRead
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        // A write landing this cycle is forwarded; register 0 has no decode
        // hit and no counter, so it naturally reads zero and never pending.
        assign rd_data[k*DATA_W +: DATA_W] =
            (addr == ADDR_ZERO) ? '0 : (wrHit[addr] ? wrVal[addr] : mem_q[addr]);

        // The retiring write is subtracted so a consumer sees the register
        // as ready in the same cycle its last producer writes back.
        assign rd_pend[k] = cnt[addr] > PEND_W'(wrHit[addr]);
    end

    // Debug record: the last (highest-index) port committing a non-zero
    // write this cycle; the old value is the stored contents before commit.
    always_comb begin
        dbgVld_d  = 1'b0;
        dbgAddr_d = dbgAddr_q;
        dbgOld_d  = dbgOld_q;
        dbgNew_d  = dbgNew_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] == RF_WRITE_ENABLED &&
                wr_addr[j*ADDR_W +: ADDR_W] != ADDR_ZERO) begin
                dbgVld_d  = 1'b1;
                dbgAddr_d = wr_addr[j*ADDR_W +: ADDR_W];
                dbgOld_d  = mem_q[wr_addr[j*ADDR_W +: ADDR_W]];
                dbgNew_d  = wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Register array, overflow pulse and debug record. Entry 0 is only ever
    // cleared, which keeps it at zero for good; reset beats any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                mem_q[a] <= '0;
            end
            rsvOvf_q  <= 1'b0;
            dbgVld_q  <= 1'b0;
            dbgAddr_q <= '0;
            dbgOld_q  <= '0;
            dbgNew_q  <= '0;
        end else begin
            for (int a = 1; a < NUM_REGS; a++) begin
                if (wrHit[a]) begin
                    mem_q[a] <= wrVal[a];
                end
            end
            rsvOvf_q  <= |ovfVec;
            dbgVld_q  <= dbgVld_d;
            dbgAddr_q <= dbgAddr_d;
            dbgOld_q  <= dbgOld_d;
            dbgNew_q  <= dbgNew_d;
        end
    end

    assign rsv_ovf     = rsvOvf_q;
    assign dbg_wr_vld  = dbgVld_q;
    assign dbg_wr_addr = dbgAddr_q;
    assign dbg_wr_old  = dbgOld_q;
    assign dbg_wr_new  = dbgNew_q;

endmodule

// File: tb/tb_rf_multiport.sv
// ---------------------------------------------------------------------------
// tb_rf_multiport
// Self-checking bench for rf_multiport with two read and two write ports.
// A behavioural model (array of register values plus array of pending
// counts) predicts reads, pending flags, overflow pulses and debug records.
// ---------------------------------------------------------------------------
module tb_rf_multiport;
    import rf_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int PW   = 2;
    localparam int NREG = 32;
    localparam int PMAX = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rdAddr;
    logic [NR*DW-1:0]  rdData;
    logic [NR-1:0]     rdPend;
    logic [NW-1:0]     wrEn;
    logic [NW*AW-1:0]  wrAddr;
    logic [NW*DW-1:0]  wrData;
    logic              rsvEn;
    logic [AW-1:0]     rsvAddr;
    logic              rsvOvf;
    logic              dbgVld;
    logic [AW-1:0]     dbgAddr;
    logic [DW-1:0]     dbgOld;
    logic [DW-1:0]     dbgNew;

    logic [DW-1:0] mReg [NREG];
    int            mPend [NREG];
    logic          mOvf;
    logic          mVld;
    logic [AW-1:0] mDAddr;
    logic [DW-1:0] mOld;
    logic [DW-1:0] mNew;
    logic          mValid = 1'b0;
    logic          mWasReset;

    int checks   = 0;
    int failures = 0;

    rf_multiport #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .NUM_WR (NW),
        .PEND_W (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rdAddr),
        .rd_data     (rdData),
        .rd_pend     (rdPend),
        .wr_en       (wrEn),
        .wr_addr     (wrAddr),
        .wr_data     (wrData),
        .rsv_en      (rsvEn),
        .rsv_addr    (rsvAddr),
        .rsv_ovf     (rsvOvf),
        .dbg_wr_vld  (dbgVld),
        .dbg_wr_addr (dbgAddr),
        .dbg_wr_old  (dbgOld),
        .dbg_wr_new  (dbgNew)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [NW-1:0] en,
                                 input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                                 input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                                 input logic ren, input logic [AW-1:0] ra,
                                 input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        reset   = rst;
        wrEn    = en;
        wrAddr  = {wa1, wa0};
        wrData  = {wd1, wd0};
        rsvEn   = ren;
        rsvAddr = ra;
        rdAddr  = {r1, r0};
    endtask

    function automatic logic modelHit(input int a);
        logic h = 1'b0;
        for (int j = 0; j < NW; j++) begin
            if (a != 0 && wrEn[j] && int'(wrAddr[j*AW +: AW]) == a) h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [DW-1:0] modelRead(input int a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = mReg[a];
        for (int j = 0; j < NW; j++) begin
            if (wrEn[j] && int'(wrAddr[j*AW +: AW]) == a) v = wrData[j*DW +: DW];
        end
        return v;
    endfunction

    function automatic logic modelPend(input int a);
        int left;
        if (a == 0) return 1'b0;
        left = mPend[a] - (modelHit(a) ? 1 : 0);
        return left > 0;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic modelClock();
        logic [NREG-1:0] hits;
        mWasReset = reset;
        if (reset) begin
            for (int a = 0; a < NREG; a++) begin
                mReg[a]  = '0;
                mPend[a] = 0;
            end
            mOvf = 0; mVld = 0; mDAddr = '0; mOld = '0; mNew = '0;
            mValid = 1'b1;
            return;
        end
        for (int a = 0; a < NREG; a++) hits[a] = modelHit(a);
        mOvf = 1'b0;
        for (int a = 1; a < NREG; a++) begin
            logic inc;
            inc = rsvEn && int'(rsvAddr) == a;
            if (inc && !hits[a]) begin
                if (mPend[a] == PMAX) mOvf = 1'b1;
                else mPend[a]++;
            end else if (hits[a] && !inc && mPend[a] > 0) begin
                mPend[a]--;
            end
        end
        mVld = 1'b0;
        for (int j = 0; j < NW; j++) begin
            if (wrEn[j] && wrAddr[j*AW +: AW] != '0) begin
                mVld   = 1'b1;
                mDAddr = wrAddr[j*AW +: AW];
                mOld   = mReg[wrAddr[j*AW +: AW]];
                mNew   = wrData[j*DW +: DW];
            end
        end
        for (int j = 0; j < NW; j++) begin
            if (wrEn[j] && wrAddr[j*AW +: AW] != '0) mReg[wrAddr[j*AW +: AW]] = wrData[j*DW +: DW];
        end
    endtask

    // One full cycle starting just after a negedge: combinational checks,
    // posedge, model update, registered checks, back to the next negedge.
    task automatic runCycle();
        #1;
        if (mValid) begin
            for (int k = 0; k < NR; k++) begin
                int a;
                a = int'(rdAddr[k*AW +: AW]);
                checkOutput($sformatf("rd_data%0d r%0d", k, a), 64'(rdData[k*DW +: DW]), 64'(modelRead(a)));
                checkOutput($sformatf("rd_pend%0d r%0d", k, a), 64'(rdPend[k]), 64'(modelPend(a)));
            end
        end
        @(posedge clk);
        modelClock();
        #1;
        checkOutput("rsv_ovf", 64'(rsvOvf), 64'(mOvf));
        checkOutput("dbg_wr_vld", 64'(dbgVld), 64'(mVld));
        if (mVld || mWasReset) begin
            checkOutput("dbg_wr_addr", 64'(dbgAddr), 64'(mDAddr));
            checkOutput("dbg_wr_old", 64'(dbgOld), 64'(mOld));
            checkOutput("dbg_wr_new", 64'(dbgNew), 64'(mNew));
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
    endtask

    task automatic reserve(input logic [AW-1:0] ra, input logic [AW-1:0] r0);
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, ra, r0, 5'd0);
    endtask

    initial begin
        // Reset, then sweep every address on both ports.
        applyStimulus(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        runCycle();
        for (int a = 0; a < NREG; a++) begin
            idle(AW'(a), AW'(NREG - 1 - a));
            #1;
            checkOutput("reset rd_data0", 64'(rdData[DW-1:0]), 64'h0);
            checkOutput("reset rd_pend", 64'(rdPend), 64'h0);
            runCycle();
        end

        // Writing register 0 has no effect.
        applyStimulus(1'b0, 2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        checkOutput("r0 bypass", 64'(rdData[DW-1:0]), 64'h0);
        runCycle();
        checkOutput("r0 dbg_vld", 64'(dbgVld), 64'h0);
        idle(5'd0, 5'd0);
        #1;
        checkOutput("r0 stored", 64'(rdData[DW-1:0]), 64'h0);
        runCycle();

        // Single write with same-cycle bypass and debug record.
        applyStimulus(1'b0, 2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        #1;
        checkOutput("r5 bypass", 64'(rdData[DW-1:0]), 64'h12345678);
        runCycle();
        checkOutput("r5 dbg_vld", 64'(dbgVld), 64'h1);
        checkOutput("r5 dbg_old", 64'(dbgOld), 64'h0);
        checkOutput("r5 dbg_new", 64'(dbgNew), 64'h12345678);
        $display("[TB] %s", $sformatf(RF_DBG_FMT, dbgAddr, dbgOld, dbgNew));
        idle(5'd5, 5'd0);
        #1;
        checkOutput("r5 stored", 64'(rdData[DW-1:0]), 64'h12345678);
        runCycle();

        // Both write ports on r7: port 1 wins.
        applyStimulus(1'b0, 2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
        checkOutput("r7 bypass0", 64'(rdData[DW-1:0]), 64'h2);
        checkOutput("r7 bypass1", 64'(rdData[2*DW-1:DW]), 64'h2);
        runCycle();
        checkOutput("r7 dbg_addr", 64'(dbgAddr), 64'h7);
        checkOutput("r7 dbg_new", 64'(dbgNew), 64'h2);
        idle(5'd7, 5'd0);
        #1;
        checkOutput("r7 stored", 64'(rdData[DW-1:0]), 64'h2);
        runCycle();

        // Saturate r3, overflow on the fourth reservation, then retire.
        reserve(5'd3, 5'd3);
        #1;
        checkOutput("r3 rsv no early pend", 64'(rdPend[0]), 64'h0);
        runCycle();
        reserve(5'd3, 5'd3);
        runCycle();
        reserve(5'd3, 5'd3);
        runCycle();
        checkOutput("r3 no ovf yet", 64'(rsvOvf), 64'h0);
        reserve(5'd3, 5'd3);
        runCycle();
        checkOutput("r3 ovf pulse", 64'(rsvOvf), 64'h1);
        idle(5'd3, 5'd0);
        runCycle();
        checkOutput("r3 ovf cleared", 64'(rsvOvf), 64'h0);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 2'b01, 5'd3, 32'(n + 100), 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
            #1;
            checkOutput($sformatf("r3 pend write%0d", n), 64'(rdPend[0]), (n == 2) ? 64'h0 : 64'h1);
            runCycle();
        end

        // Reserve and retire r9 in the same cycle leaves the count at 1.
        reserve(5'd9, 5'd9);
        runCycle();
        applyStimulus(1'b0, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        runCycle();
        idle(5'd9, 5'd0);
        #1;
        checkOutput("r9 still pend", 64'(rdPend[0]), 64'h1);
        runCycle();
        applyStimulus(1'b0, 2'b01, 5'd9, 32'h98, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
        #1;
        checkOutput("r9 retire", 64'(rdPend[0]), 64'h0);
        runCycle();

        // Reset in the middle of a write and with r3 pending.
        reserve(5'd3, 5'd3);
        runCycle();
        reserve(5'd3, 5'd3);
        runCycle();
        applyStimulus(1'b1, 2'b01, 5'd4, 32'hAAAA5555, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
        runCycle();
        checkOutput("mid reset dbg_vld", 64'(dbgVld), 64'h0);
        idle(5'd4, 5'd3);
        #1;
        checkOutput("mid reset r4", 64'(rdData[DW-1:0]), 64'h0);
        checkOutput("mid reset r3 pend", 64'(rdPend[1]), 64'h0);
        runCycle();

        // Randomised traffic on a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          NW'($urandom_range(0, 3)),
                          AW'($urandom_range(0, 9)), $urandom(),
                          AW'($urandom_range(0, 9)), $urandom(),
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 9)),
                          AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11)));
            runCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
